// File: rtl/irq_rr_sched_pkg.sv
// Shared types and defaults for the round-robin interrupt scheduler.
// Imported by the interface, the picker and the top module.
package irq_sched_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2,
        RELEASE  = 2'd3
    } state_e;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_TIMEOUT = 15;
    localparam int DEF_CW      = 4;
    localparam int MAX_NREQ    = 8;

    // Callers narrow the result to their own requester count with a size cast.
    function automatic logic [MAX_NREQ-1:0] onehot(input logic [2:0] idx);
        return MAX_NREQ'(1) << idx;
    endfunction

endpackage

// File: rtl/irq_rr_sched_if.sv
// Requester/handler signal bundle between the scheduler and its environment.
// The scheduler uses the slave view; whatever drives the requests uses master.
interface irq_rr_sched_if
    import irq_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
);

    logic [NREQ-1:0] req;
    logic [NREQ-1:0] req_cont;
    logic            ackout;
    logic            enable_count;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] done;
    logic            err;
    logic            eql;
    logic            cont_eql;
    logic            busy;

    modport master (
        output req, req_cont, ackout, enable_count,
        input  grant, done, err, eql, cont_eql, busy
    );

    modport slave (
        input  req, req_cont, ackout, enable_count,
        output grant, done, err, eql, cont_eql, busy
    );

endinterface

// File: rtl/irq_rr_sched_rr_pick.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping around to bit 0.
module rr_pick
    import irq_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic            valid_o,
    output logic [IW-1:0]   winner_o
);

    int idx;

    // Walk from the farthest candidate back to the pointer so the closest hit is written last.
    always_comb begin
        valid_o  = 1'b0;
        winner_o = '0;
        idx      = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = (int'(ptr_i) + i) % NREQ;
            if (req_i[IW'(idx)]) begin
                valid_o  = 1'b1;
                winner_o = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/irq_rr_sched.sv
// Round-robin scheduler that time-shares one interrupt-handler FSM among
// NREQ requesters, with ack handshake, timeout abort and priority rotation.
module irq_rr_sched
    import irq_sched_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CW      = DEF_CW
) (
    input  logic          clock,
    input  logic          reset,
    irq_rr_sched_if.slave bus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   winner_q, winner_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            err_q, err_d;
    logic            eql_q, eql_d;
    logic            contEql_q, contEql_d;
    logic            busy_q, busy_d;
    logic            pickValid;
    logic [IW-1:0]   pickIdx;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req_i    (bus.req),
        .ptr_i    (ptr_q),
        .valid_o  (pickValid),
        .winner_o (pickIdx)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            winner_q  <= '0;
            cnt_q     <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            eql_q     <= 1'b0;
            contEql_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            winner_q  <= winner_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            err_q     <= err_d;
            eql_q     <= eql_d;
            contEql_q <= contEql_d;
            busy_q    <= busy_d;
        end
    end

    // done/err are pulses, so they default low; everything else holds.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        winner_d  = winner_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        done_d    = '0;
        err_d     = 1'b0;
        eql_d     = eql_q;
        contEql_d = contEql_q;

        case (state_q)
            IDLE: begin
                if (pickValid && !bus.enable_count) begin
                    winner_d  = pickIdx;
                    grant_d   = NREQ'(onehot(3'(pickIdx)));
                    contEql_d = bus.req_cont[pickIdx];
                    eql_d     = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (!bus.req[winner_q] || bus.ackout || cnt_q == CW'(TIMEOUT - 1)) begin
                    if (bus.req[winner_q] && bus.ackout) begin
                        done_d = grant_q;
                    end else if (bus.req[winner_q]) begin
                        err_d = 1'b1;
                    end
                    state_d   = RELEASE;
                    eql_d     = 1'b0;
                    contEql_d = 1'b0;
                    grant_d   = '0;
                    ptr_d     = (winner_q == IW'(NREQ - 1)) ? '0 : winner_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RELEASE: begin
                if (!bus.ackout) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.grant    = grant_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.eql      = eql_q;
    assign bus.cont_eql = contEql_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_irq_rr_sched.sv
// Directed testbench for irq_rr_sched: reset, single service, fairness,
// timeout, ack/timeout collision, withdrawal, busy blocking and mid-op reset.
module tb_irq_rr_sched;
    import irq_sched_pkg::*;

    logic clock;
    logic reset;
    int   checkCount;
    int   passCount;

    irq_rr_sched_if #(.NREQ(4)) bus ();

    irq_rr_sched #(
        .NREQ    (4),
        .TIMEOUT (15),
        .CW      (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] rc, input logic ack, input logic en);
        bus.req          = r;
        bus.req_cont     = rc;
        bus.ackout       = ack;
        bus.enable_count = en;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Packed view: {grant, done, err, eql, cont_eql, busy}
    function automatic logic [31:0] outVec();
        return {20'd0, bus.grant, bus.done, bus.err, bus.eql, bus.cont_eql, bus.busy};
    endfunction

    // Starts in IDLE with req already applied; acks on the third cycle after grant.
    task automatic serveOne(input string tag, input logic [3:0] expGrant, input logic expCont);
        tick();
        checkOutput({tag, "_grant"}, outVec(), {20'd0, expGrant, 4'b0000, 1'b0, 1'b1, expCont, 1'b1});
        tick();
        tick();
        bus.ackout = 1'b1;
        tick();
        checkOutput({tag, "_done"}, outVec(), {20'd0, 4'b0000, expGrant, 1'b0, 1'b0, 1'b0, 1'b1});
        bus.ackout = 1'b0;
        tick();
        checkOutput({tag, "_idle"}, outVec(), 32'd0);
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        reset      = 1'b1;
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);

        // Reset and idle
        #2 reset = 1'b0;
        #1 checkOutput("reset_async", outVec(), 32'd0);
        #4 reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("idle_quiet", outVec(), 32'd0);
        end

        // Single service from pointer 0
        applyStimulus(4'b0001, 4'b0001, 1'b0, 1'b0);
        serveOne("single", 4'b0001, 1'b1);
        bus.req = 4'b0000;

        // Pointer is now 1, so bit 1 beats bit 0
        applyStimulus(4'b0011, 4'b0000, 1'b0, 1'b0);
        serveOne("ptr_one", 4'b0010, 1'b0);
        bus.req = 4'b0000;

        reset = 1'b0;
        #3 reset = 1'b1;
        tick();

        // Fairness with all requesters pending
        applyStimulus(4'b1111, 4'b1010, 1'b0, 1'b0);
        serveOne("rr0", 4'b0001, 1'b0);
        serveOne("rr1", 4'b0010, 1'b1);
        serveOne("rr2", 4'b0100, 1'b0);
        serveOne("rr3", 4'b1000, 1'b1);
        serveOne("rr4", 4'b0001, 1'b0);
        bus.req = 4'b0000;

        // Timeout: pointer 1, requester 2 never acknowledged
        applyStimulus(4'b0100, 4'b0000, 1'b0, 1'b0);
        tick();
        checkOutput("to_grant", {28'd0, bus.grant}, 32'h4);
        tick();
        for (int j = 1; j <= 14; j++) begin
            tick();
            checkOutput("to_wait", {31'd0, bus.err}, 32'd0);
        end
        tick();
        checkOutput("to_err", outVec(), {20'd0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1});
        tick();
        checkOutput("to_after", outVec(), 32'd0);
        bus.req = 4'b0000;

        // Ack on the timeout edge: pointer 3 picks requester 3, ack wins
        applyStimulus(4'b1001, 4'b0000, 1'b0, 1'b0);
        tick();
        checkOutput("col_grant", {28'd0, bus.grant}, 32'h8);
        tick();
        for (int j = 1; j <= 14; j++) tick();
        checkOutput("col_pre", {31'd0, bus.eql}, 32'd1);
        bus.ackout = 1'b1;
        tick();
        checkOutput("col_done", outVec(), {20'd0, 4'b0000, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b1});
        bus.ackout = 1'b0;
        tick();
        bus.req = 4'b0000;
        checkOutput("col_idle", outVec(), 32'd0);

        // Withdrawal: pointer 0 picks requester 1, then it drops
        applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b0);
        tick();
        checkOutput("wd_grant", {28'd0, bus.grant}, 32'h2);
        tick();
        tick();
        bus.req = 4'b0000;
        tick();
        checkOutput("wd_release", outVec(), {20'd0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1});
        tick();
        checkOutput("wd_idle", outVec(), 32'd0);

        // Handler busy blocks grants
        applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("blk_hold", outVec(), 32'd0);
        end
        bus.enable_count = 1'b0;
        tick();
        checkOutput("blk_grant", {28'd0, bus.grant}, 32'h2);
        tick();
        tick();

        // Reset during WAIT_ACK clears outputs without waiting for an edge
        reset = 1'b0;
        #1 checkOutput("mid_reset", outVec(), 32'd0);
        tick();
        checkOutput("mid_reset_hold", outVec(), 32'd0);
        bus.req = 4'b0000;
        reset = 1'b1;
        tick();
        checkOutput("post_reset", outVec(), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
